// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage data-memory access unit:
// opcodes, FSM states, access sizes and the byte-enable helper.
package mips_mem_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    // Little-endian lane enables for an aligned access of the given size.
    function automatic logic [3:0] byte_en(input size_t sz, input logic [1:0] a);
        case (sz)
            SZ_B:    return 4'b0001 << a;
            SZ_H:    return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Selects the addressed byte/halfword lane of a read word and
// sign- or zero-extends it according to the load opcode.
module mem_load_align
    import mips_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [5:0]  opcode,
    output logic [31:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic        sext;

    always_comb begin
        case (addr)
            2'd0:    lane_b = rdata[7:0];
            2'd1:    lane_b = rdata[15:8];
            2'd2:    lane_b = rdata[23:16];
            default: lane_b = rdata[31:24];
        endcase
        lane_h = addr[1] ? rdata[31:16] : rdata[15:0];
        sext   = (opcode == OP_LB) || (opcode == OP_LH);

        case (opcode)
            OP_LB, OP_LBU: data = {{24{sext & lane_b[7]}}, lane_b};
            OP_LH, OP_LHU: data = {{16{sext & lane_h[15]}}, lane_h};
            default:       data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: runs one request/ack transaction per access,
// stalls the pipeline until it completes and registers the extended load data.
module mem_access_unit
    import mips_mem_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MEM_RD_EN,
    input  logic        MEM_WR_EN,
    input  logic [5:0]  MEM_Opcode,
    input  logic [31:0] MEM_ALU_RESULT,
    input  logic [31:0] MEM_RT_DATA,
    output logic        STALL,
    output logic [31:0] MEM_LOAD_DATA,
    output logic        MEM_ADDR_ERR,
    output logic        DMEM_REQ,
    output logic        DMEM_WE,
    output logic [31:0] DMEM_ADDR,
    output logic [3:0]  DMEM_BE,
    output logic [31:0] DMEM_WDATA,
    input  logic [31:0] DMEM_RDATA,
    input  logic        DMEM_ACK
);

    state_t      state, state_nxt;
    size_t       size;
    logic        is_load, is_store, misaligned, acc_ok;
    logic [31:0] wdata_nxt, load_ext;
    logic [5:0]  op_q;
    logic [1:0]  lane_q;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        size     = SZ_W;
        case (MEM_Opcode)
            OP_LB, OP_LBU: begin is_load  = 1'b1; size = SZ_B; end
            OP_LH, OP_LHU: begin is_load  = 1'b1; size = SZ_H; end
            OP_LW:         begin is_load  = 1'b1; size = SZ_W; end
            OP_SB:         begin is_store = 1'b1; size = SZ_B; end
            OP_SH:         begin is_store = 1'b1; size = SZ_H; end
            OP_SW:         begin is_store = 1'b1; size = SZ_W; end
            default: ;
        endcase
        misaligned = ((size == SZ_H) && MEM_ALU_RESULT[0]) ||
                     ((size == SZ_W) && (MEM_ALU_RESULT[1:0] != 2'b00));
        acc_ok = (MEM_RD_EN ^ MEM_WR_EN) &&
                 ((MEM_RD_EN && is_load) || (MEM_WR_EN && is_store)) &&
                 !misaligned;
        case (size)
            SZ_B:    wdata_nxt = {4{MEM_RT_DATA[7:0]}};
            SZ_H:    wdata_nxt = {2{MEM_RT_DATA[15:0]}};
            default: wdata_nxt = MEM_RT_DATA;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    // DONE lets the finished instruction leave EX/MEM before inputs are looked at again.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (acc_ok)   state_nxt = REQ;
            REQ:     if (DMEM_ACK) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        STALL        = ((state == IDLE) && acc_ok) || (state == REQ);
        MEM_ADDR_ERR = (state == IDLE) && (MEM_RD_EN || MEM_WR_EN) && !acc_ok;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            DMEM_REQ   <= 1'b0;
            DMEM_WE    <= 1'b0;
            DMEM_ADDR  <= '0;
            DMEM_BE    <= '0;
            DMEM_WDATA <= '0;
            op_q       <= '0;
            lane_q     <= '0;
        end else if (state == IDLE && acc_ok) begin
            DMEM_REQ   <= 1'b1;
            DMEM_WE    <= MEM_WR_EN;
            DMEM_ADDR  <= {MEM_ALU_RESULT[31:2], 2'b00};
            DMEM_BE    <= byte_en(size, MEM_ALU_RESULT[1:0]);
            DMEM_WDATA <= wdata_nxt;
            op_q       <= MEM_Opcode;
            lane_q     <= MEM_ALU_RESULT[1:0];
        end else if (state == REQ && DMEM_ACK) begin
            DMEM_REQ   <= 1'b0;
        end
    end

    mem_load_align u_align (
        .rdata  (DMEM_RDATA),
        .addr   (lane_q),
        .opcode (op_q),
        .data   (load_ext)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)                                  MEM_LOAD_DATA <= '0;
        else if (state == REQ && DMEM_ACK && !DMEM_WE) MEM_LOAD_DATA <= load_ext;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage data-memory access unit for the five-stage MIPS pipeline. It sits downstream of the EX/MEM pipeline register and consumes its opcode, ALU-computed address and store data. For each load or store it runs a request/acknowledge transaction on the data-memory bus, handling byte-lane alignment and sign/zero extension. It stalls the pipeline until the transaction completes and presents extended load data to the MEM/WB register.

## Interface
- No parameters; all widths fixed at 32-bit data and address.
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-high.
- MEM_RD_EN  in  1  MemRead control for the instruction in MEM.
- MEM_WR_EN  in  1  MemWrite control for the instruction in MEM.
- MEM_Opcode  in  6  instruction opcode:
  - loads: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25
  - stores: SB 0x28, SH 0x29, SW 0x2B
- MEM_ALU_RESULT  in  32  effective byte address.
- MEM_RT_DATA  in  32  store data, right-justified.
- STALL  out  1  freezes PC, IF/ID, ID/EX and EX/MEM.
- MEM_LOAD_DATA  out  32  extended load result, registered.
- MEM_ADDR_ERR  out  1  misaligned, illegal or conflicting access.
- DMEM_REQ  out  1  bus request.
- DMEM_WE  out  1  1 = write.
- DMEM_ADDR  out  32  word address (bits [1:0] forced to 0).
- DMEM_BE  out  4  byte enables; bit n = byte lane n.
- DMEM_WDATA  out  32  lane-positioned write data.
- DMEM_RDATA  in  32  read data, valid with DMEM_ACK.
- DMEM_ACK  in  1  single-cycle completion strobe.

## Operation
- Byte ordering is little-endian: byte lane = addr[1:0]; halfword lane = addr[1].
- A valid access is MEM_RD_EN xor MEM_WR_EN, with an opcode matching that direction and a naturally aligned address.
- FSM states and transitions:
  - IDLE → REQ on a valid access. Address, BE, WE and WDATA are captured into registers at that edge.
  - REQ → DONE on DMEM_ACK.
  - DONE → IDLE unconditionally.
- DONE exists so the completed instruction leaves EX/MEM without being reissued. Inputs are ignored in DONE.
- Store lanes:
  - SB: BE = 1<<addr[1:0]; WDATA = the byte replicated ×4.
  - SH: BE = 4'b0011 or 4'b1100; WDATA = the halfword replicated ×2.
  - SW: BE = 4'b1111.
- Loads: the lane is selected from DMEM_RDATA and extended (LB/LH sign-extend; LBU/LHU zero-extend). The result is registered into MEM_LOAD_DATA on the ACK edge. Stores leave MEM_LOAD_DATA unchanged.
- Errors, evaluated in IDLE only:
  - Conditions: halfword with addr[0]=1; word with addr[1:0]≠0; both enables high; opcode not matching the asserted enable.
  - Response: MEM_ADDR_ERR is high combinationally, no bus transaction, STALL low, state stays IDLE.
- Reset values (also applied asynchronously mid-transaction): state IDLE, DMEM_REQ 0, DMEM_WE 0, DMEM_ADDR 0, DMEM_BE 0, DMEM_WDATA 0, MEM_LOAD_DATA 0, STALL 0, MEM_ADDR_ERR 0.

## Timing
- STALL = (IDLE and valid access) or REQ. It is combinational from the inputs in IDLE.
- DMEM_REQ is registered and high for every REQ cycle. DMEM_ADDR, DMEM_BE, DMEM_WE and DMEM_WDATA are stable while REQ is high.
- DMEM_REQ drops in the cycle after the ACK.
- DMEM_ACK outside REQ is ignored.
- Minimum access is 3 cycles: IDLE-detect (stall), REQ with ACK (stall), DONE (no stall).
- Each extra memory wait cycle adds one stall cycle.
- MEM_LOAD_DATA is valid during DONE, when MEM/WB captures it, and holds until the next load's ACK.
- Back-to-back accesses: the next instruction reaches MEM after DONE, giving one bubble-free IDLE detect.
- A non-memory instruction in IDLE: STALL 0, no bus activity.

## Structure
- Package mips_mem_pkg holds:
  - opcode localparams (OP_LB … OP_SW)
  - the FSM state enum (IDLE, REQ, DONE)
  - a function computing byte enables from size and addr[1:0]
- Sub-module mem_load_align: combinational lane select plus sign/zero extension (in: rdata, addr[1:0], opcode; out: 32-bit extended data). It is instantiated once.
- FSM, request registers and stall logic live in mem_access_unit.

## Test plan
- LW addr 0x100, ACK on first REQ cycle, RDATA 0xDEADBEEF:
  - STALL high 2 cycles; REQ for 1 cycle with BE 4'b1111.
  - MEM_LOAD_DATA = 0xDEADBEEF in DONE.
- LB vs LBU addr 0x103, RDATA 0x80FFFFFF:
  - LB → 0xFFFFFF80; LBU → 0x00000080.
- SH addr 0x102, RT 0x0000ABCD, ACK after 3 wait cycles:
  - BE 4'b1100, WDATA 0xABCDABCD, WE 1.
  - STALL high 5 cycles; attributes stable throughout REQ.
- LW addr 0x101:
  - MEM_ADDR_ERR 1, STALL 0, DMEM_REQ stays 0.
- RESET pulse while in REQ:
  - DMEM_REQ, STALL and MEM_LOAD_DATA go to 0 immediately.
  - A later ACK is ignored; the next LW completes normally.
